// File: rtl/ex_flag_stage_pkg.sv
// Shared definitions for the execute-stage flag/EX-MEM back end:
// opcode encoding, flag bit positions, saturation limits and decode helpers.
package ex_flag_stage_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    localparam int FLG_Z = 2;
    localparam int FLG_V = 1;
    localparam int FLG_N = 0;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    function automatic logic is_addsub(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // LW/SW carry an address computed by the adder, so they take the sum path too.
    function automatic logic uses_sum(input logic [3:0] op);
        return is_addsub(op) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] flag_we_mask(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB: begin
                m[FLG_Z] = 1'b1;
                m[FLG_V] = 1'b1;
                m[FLG_N] = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLG_Z] = 1'b1;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ex_flag_stage_flag_reg.sv
// Architectural Z/V/N flag register: per-bit write enables, plus the value
// each bit will take at the next edge for same-cycle forwarding.
module ex_flag_stage_flag_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] we,
    input  logic [2:0] d,
    output logic [2:0] q,
    output logic [2:0] nxt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (we[i]) q[i] <= d[i];
            end
        end
    end

    assign nxt = (we & d) | (~we & q);

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: ADD/SUB saturation, Z/V/N generation, flag
// register update and the EX/MEM pipeline register.
module ex_flag_stage
    import ex_flag_stage_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter bit FLAG_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] sum,
    input  logic             ovfl,
    input  logic [WIDTH-1:0] alu_other,
    input  logic             stall,
    input  logic             flush,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_result,
    output logic [3:0]       mem_opcode,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic [2:0]       flags_fwd
);

    logic [WIDTH-1:0] result;
    logic [2:0]       flag_d;
    logic [2:0]       flag_we;
    logic [2:0]       flag_q;
    logic [2:0]       flag_nxt;
    logic             wr_ok;

    // A wrapped sum with the sign bit set means the true result overflowed positive.
    always_comb begin
        result = uses_sum(opcode) ? sum : alu_other;
        if (is_addsub(opcode) && ovfl) begin
            result = sum[WIDTH-1] ? SAT_POS : SAT_NEG;
        end
    end

    always_comb begin
        flag_d        = 3'b000;
        flag_d[FLG_Z] = (result == '0);
        flag_d[FLG_V] = ovfl;
        flag_d[FLG_N] = result[WIDTH-1];
    end

    assign wr_ok   = ex_valid & ~stall & ~flush;
    assign flag_we = wr_ok ? flag_we_mask(opcode) : 3'b000;

    ex_flag_stage_flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flag_we),
        .d     (flag_d),
        .q     (flag_q),
        .nxt   (flag_nxt)
    );

    // Flush only kills the valid bit; the data fields are don't-care downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_opcode <= 4'h0;
        end else if (flush) begin
            mem_valid  <= 1'b0;
        end else if (!stall) begin
            mem_valid  <= ex_valid;
            mem_result <= result;
            mem_opcode <= opcode;
        end
    end

    assign flag_z    = flag_q[FLG_Z];
    assign flag_v    = flag_q[FLG_V];
    assign flag_n    = flag_q[FLG_N];
    assign flags_fwd = FLAG_BYPASS ? flag_nxt : flag_q;

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Execute-stage back end that consumes the 16-bit add/subtract unit's Sum/overflow and the other ALU results.
- Applies ADD/SUB saturation and computes Z/V/N.
- Maintains the architectural flag register and drives the EX/MEM pipeline register.
- Sits directly downstream of addsub_16bit. Feeds the MEM stage, and feeds the branch unit through the flag outputs.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- FLAG_BYPASS, 1, if 1, flags_fwd shows next-cycle flags combinationally for a same-cycle branch; if 0, flags_fwd equals the registered flags.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  an instruction in EX this cycle.
- opcode  input  4  instruction opcode in EX.
- sum  input  WIDTH  Sum from the add/subtract unit.
- ovfl  input  1  overflow from the add/subtract unit.
- alu_other  input  WIDTH  result of the non-add ops (XOR, RED, shifts, PADDSB, LLB/LHB, PCS).
- stall  input  1  hold EX/MEM and flags.
- flush  input  1  squash the EX instruction.
- mem_valid  output  1  EX/MEM register holds a live instruction.
- mem_result  output  WIDTH  registered result.
- mem_opcode  output  4  registered opcode.
- flag_z, flag_v, flag_n  output  1 each  architectural flags.
- flags_fwd  output  3  {Z,V,N} for branch resolution.

Behaviour:
- Reset (async, rst_n=0): mem_valid=0, mem_result=16'h0000, mem_opcode=4'h0, flag_z=0, flag_v=0, flag_n=0.
  - Reset applies immediately, mid-operation included.
  - Release is synchronous to the next clk edge.
- Opcodes: ADD=0000, SUB=0001, XOR=0010, RED=0011, SLL=0100, SRA=0101, ROR=0110, PADDSB=0111, LW=1000, SW=1001, LLB=1010, LHB=1011, B=1100, BR=1101, PCS=1110, HLT=1111.
- Result select (combinational):
  - ADD/SUB/LW/SW: sum path.
  - All other opcodes: alu_other.
- Saturation (ADD and SUB only):
  - ovfl=1 and sum[15]=1 (positive overflow): result 16'h7FFF.
  - ovfl=1 and sum[15]=0 (negative overflow): result 16'h8000.
  - ovfl=0: result is sum unchanged.
  - LW/SW address sums are never saturated.
- Flag computation, on the final (post-saturation) result:
  - Z = (result == 0).
  - N = result[15].
  - V = ovfl.
- Flag write enable, effective only when ex_valid & ~stall & ~flush:
  - ADD/SUB: write Z, V, N.
  - XOR/SLL/SRA/ROR: write Z only; V and N hold.
  - All others: no flag write.
- Pipeline register update, each rising edge:
  - flush=1: mem_valid<=0 and flags hold. flush wins over stall.
  - else stall=1: all EX/MEM fields and flags hold.
  - else: mem_valid<=ex_valid, mem_result<=result, mem_opcode<=opcode.
  - When ex_valid=0 in the not-stalled case, the data fields still load; downstream qualifies on mem_valid.
- Latency: one cycle from EX inputs to mem_result/flags.
- flags_fwd:
  - FLAG_BYPASS=1: shows the value the flags will take at the next edge (the write-enabled fields replaced by new values), for a branch resolved in the cycle after a flag-setting op.
  - FLAG_BYPASS=0: equals the registered flags.
- Back-to-back flag writers: the last non-stalled, non-flushed writer wins; no accumulation.
- HLT: passes through like any non-flag op; halting is handled elsewhere.

Decomposition:
- Shared include file wisc_defs.vh holds:
  - opcode constants (OP_ADD ... OP_HLT);
  - flag bit indices FLG_Z=2, FLG_V=1, FLG_N=0;
  - saturation constants SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
- One sub-module, flag_reg: three async-reset DFFs with individual write enables, plus next-value outputs for the bypass.

Test Plan:
- Reset mid-stream: assert rst_n=0 between edges -> all outputs 0 immediately; after release, the first ADD 0x0001+0x0001 gives mem_result=0x0002, Z=0, V=0, N=0.
- ADD sum=0x8000, ovfl=1 (0x7FFF+0x0001) -> mem_result=0x7FFF, V=1, N=0, Z=0. SUB sum=0x7FFF, ovfl=1 (0x8000-0x0001) -> mem_result=0x8000, V=1, N=1.
- SUB sum=0x0000, ovfl=0 -> Z=1, N=0, V=0. Then XOR alu_other=0x00F0 -> Z=0, N and V unchanged. Then LLB -> flags unchanged.
- stall=1 for 3 cycles with new inputs each cycle -> mem_* and flags frozen; the cycle after stall drops, the current inputs load.
- flush=1 together with stall=1 on an ADD with ovfl=1 -> mem_valid=0 next cycle and V not set.
- FLAG_BYPASS=1: ADD giving 0x0000 -> flags_fwd Z bit=1 in the same cycle, before the edge; FLAG_BYPASS=0 -> flags_fwd shows Z only after the edge.
